dmem_responder: RTL and testbench

- Data-memory responder for the 16-bit CPU. It sits at the memory end of the store/load path that the control decoder drives through memwrite and memtoreg.
- The datapath acts as initiator and issues word requests on a valid/ready handshake. This block answers each request after a programmable number of wait states.
- Stores (st) commit a word into the array. Loads (ld) return a word for register writeback.
- Exactly one request is outstanding at a time, with no reordering.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/dmem_array.sv | 22 ++
 rtl/dmem_responder.sv | 91 +++++++++
 tb/tb_dmem_responder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, responder FSM encoding and the
// load/store opcodes the initiator maps onto req_we.
package cpu_pkg;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_ST = 3'b011;
  localparam logic [2:0] OP_LD = 3'b100;

  function automatic logic op_is_store(input logic [2:0] op);
    return op == OP_ST;
  endfunction
endpackage

// File: rtl/dmem_array.sv
// Synchronous single-port word RAM; rdata is registered and only moves on
// an enabled access, so it holds across the response phase.
module dmem_array #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding word request, answered after
// LATENCY wait states, with an out-of-range error path.
module dmem_responder #(
  parameter int DATA_W  = cpu_pkg::DATA_W,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [15:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  import cpu_pkg::*;

  localparam bit         ZL     = (LATENCY == 0);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t              state, nxt;
  logic [3:0]          cnt;
  logic                we_q, err_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                acc, oor, fire;
  logic                mem_en, mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata, mem_rdata;

  assign acc = req_valid && (state == IDLE);
  // Shifting by ADDR_W keeps the check legal (and constant 0) when ADDR_W==16.
  assign oor = (req_addr >> ADDR_W) != 16'd0;

  // Zero latency performs the access on the accept edge straight off the bus.
  assign fire      = ZL ? acc : (state == WAIT && cnt == 4'd0);
  assign mem_addr  = ZL ? req_addr[ADDR_W-1:0] : addr_q;
  assign mem_we    = ZL ? req_we : we_q;
  assign mem_wdata = ZL ? req_wdata : wdata_q;
  assign mem_en    = fire && !(ZL ? oor : err_q);

  dmem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (acc) nxt = ZL ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) nxt = RESP;
      RESP:    if (rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= nxt;
      if (acc) begin
        we_q    <= req_we;
        err_q   <= oor;
        addr_q  <= req_addr[ADDR_W-1:0];
        wdata_q <= req_wdata;
        cnt     <= LAT_M1;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !we_q && !err_q) ? mem_rdata : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance against a
// word-array reference model, directed cases then random traffic.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid, req_we, rsp_ready;
  logic [15:0] req_addr, req_wdata;
  logic        rdy2, vld2, err2, rdy0, vld0, err0;
  logic [15:0] rd2, rd0;
  int          checks = 0;
  int          failures = 0;

  logic [15:0] mdl [2][256];
  bit          kn  [2][256];

  always #5 clk = ~clk;

  dmem_responder #(.DATA_W(16), .ADDR_W(8), .LATENCY(2)) u2 (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~sel), .req_ready(rdy2),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld2), .rsp_ready(rsp_ready), .rsp_rdata(rd2), .rsp_err(err2));

  dmem_responder #(.DATA_W(16), .ADDR_W(8), .LATENCY(0)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid & sel), .req_ready(rdy0),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(vld0), .rsp_ready(rsp_ready), .rsp_rdata(rd0), .rsp_err(err0));

  logic        c_rdy, c_vld, c_err;
  logic [15:0] c_rd;
  int          lat;
  always_comb begin
    c_rdy = sel ? rdy0 : rdy2;
    c_vld = sel ? vld0 : vld2;
    c_err = sel ? err0 : err2;
    c_rd  = sel ? rd0  : rd2;
    lat   = sel ? 0 : 2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request from IDLE through its response handshake; ends at a negedge.
  task automatic txn(input bit we, input logic [15:0] addr, input logic [15:0] wd,
                     input int hold, input string tag);
    int k;
    int d;
    bit oor, known;
    logic [15:0] exp;
    d     = sel ? 1 : 0;
    oor   = addr[15:8] != 8'd0;
    exp   = 16'd0;
    known = 1;
    if (!we && !oor) begin
      exp   = mdl[d][addr[7:0]];
      known = kn[d][addr[7:0]];
    end
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd;
    rsp_ready = (hold == 0);
    chk({tag, ".ready"}, 32'(c_rdy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    k = 1;
    while (!c_vld && k < 40) begin @(negedge clk); k++; end
    chk({tag, ".latency"}, k, lat + 1);
    chk({tag, ".err"}, 32'(c_err), 32'(oor));
    if (known) chk({tag, ".rdata"}, 32'(c_rd), 32'(exp));
    for (int i = 0; i < hold; i++) begin
      req_valid = 1; req_we = 0;
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(c_vld), 32'd1);
      chk({tag, ".hold_ready"}, 32'(c_rdy), 32'd0);
      if (known) chk({tag, ".hold_rdata"}, 32'(c_rd), 32'(exp));
    end
    req_valid = 0;
    rsp_ready = 1;
    @(negedge clk);
    chk({tag, ".post_valid"}, 32'(c_vld), 32'd0);
    chk({tag, ".post_ready"}, 32'(c_rdy), 32'd1);
    chk({tag, ".post_rdata"}, 32'(c_rd), 32'd0);
    rsp_ready = 0;
    if (we && !oor) begin
      mdl[d][addr[7:0]] = wd;
      kn[d][addr[7:0]]  = 1;
    end
  endtask

  // req_valid held with rsp_ready high: accepts must be lat+2 cycles apart.
  task automatic period(input string tag);
    int idx[$];
    int k;
    req_valid = 1; req_we = 0; req_addr = 16'h0000; rsp_ready = 1;
    for (int n = 0; n < 3 * (lat + 2) + 1; n++) begin
      if (c_rdy) idx.push_back(n);
      @(negedge clk);
    end
    req_valid = 0;
    chk({tag, ".accepts"}, 32'(idx.size() >= 3), 32'd1);
    if (idx.size() >= 3) begin
      chk({tag, ".period1"}, idx[1] - idx[0], lat + 2);
      chk({tag, ".period2"}, idx[2] - idx[1], lat + 2);
    end
    k = 0;
    while ((!c_rdy || c_vld) && k < 40) begin @(negedge clk); k++; end
    chk({tag, ".drain"}, 32'(k < 40), 32'd1);
    rsp_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    rst = 1; sel = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    @(negedge clk);
    chk("rst.ready2", 32'(rdy2), 32'd1);
    chk("rst.valid2", 32'(vld2), 32'd0);
    chk("rst.rdata2", 32'(rd2), 32'd0);
    chk("rst.err2", 32'(err2), 32'd0);
    chk("rst.ready0", 32'(rdy0), 32'd1);
    chk("rst.valid0", 32'(vld0), 32'd0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);

    sel = 0;
    txn(1, 16'h0005, 16'hBEEF, 0, "st5");
    txn(0, 16'h0005, 16'h0000, 0, "ld5");
    sel = 1;
    txn(1, 16'h0003, 16'h1234, 0, "z_st3");
    txn(0, 16'h0003, 16'h0000, 0, "z_ld3");
    sel = 0;
    txn(1, 16'h0105, 16'hAAAA, 0, "oor_st");
    txn(0, 16'h0005, 16'h0000, 0, "oor_ld5");
    txn(0, 16'h0305, 16'h0000, 0, "oor_ld");
    txn(1, 16'h00FF, 16'h5A5A, 0, "bp_st");
    txn(0, 16'h00FF, 16'h0000, 5, "bp_ld");

    // reset one cycle into WAIT aborts the pending store
    txn(1, 16'h0010, 16'h0000, 0, "rw_clr");
    req_valid = 1; req_we = 1; req_addr = 16'h0010; req_wdata = 16'hCAFE;
    @(posedge clk);
    @(negedge clk);
    req_valid = 0;
    rst = 1;
    #1;
    chk("rw.ready", 32'(rdy2), 32'd1);
    chk("rw.valid", 32'(vld2), 32'd0);
    chk("rw.rdata", 32'(rd2), 32'd0);
    chk("rw.err", 32'(err2), 32'd0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    txn(0, 16'h0010, 16'h0000, 0, "rw_ld");

    txn(1, 16'h00FF, 16'hFFFF, 0, "wr_stff");
    txn(1, 16'h0000, 16'h0001, 0, "wr_st0");
    txn(0, 16'h00FF, 16'h0000, 0, "wr_ldff");
    txn(0, 16'h0000, 16'h0000, 0, "wr_ld0");

    sel = 0; period("per2");
    sel = 1; period("per0");

    for (int n = 0; n < 60; n++) begin
      sel = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0)
        a = {8'($urandom_range(1, 255)), 8'($urandom_range(0, 255))};
      else
        a = 16'($urandom_range(0, 15));
      txn(1'($urandom_range(0, 1)), a, 16'($urandom), $urandom_range(0, 3), "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
